// File: rtl/tt_dpll_pkg.sv
// rtl/tt_dpll_pkg.sv - shared types and defaults for the DPLL scan master
package tt_dpll_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } scan_state_e;

    localparam int DPLL_SCAN_LEN = 32;

endpackage

// File: rtl/tt_dpll_scan_master.sv
// rtl/tt_dpll_scan_master.sv - serialises a config word into the DPLL scan chain
// and captures the word the chain shifts out.
module tt_dpll_scan_master
    import tt_dpll_pkg::*;
#(
    parameter int CHAIN_LEN = DPLL_SCAN_LEN,
    parameter int SHIFT_DIV = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [CHAIN_LEN-1:0] i_wdata,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [CHAIN_LEN-1:0] o_rdata,
    output logic                 o_scan_en,
    output logic                 o_scan_out,
    input  logic                 i_scan_in
);

    localparam int BW = $clog2(CHAIN_LEN + 1);
    localparam int DW = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(CHAIN_LEN);
    localparam logic [DW-1:0] DIV_LAST = DW'(SHIFT_DIV - 1);

    if (CHAIN_LEN < 2) begin : g_bad_chain_len
        $error("tt_dpll_scan_master: CHAIN_LEN must be >= 2");
    end
    if (SHIFT_DIV < 1) begin : g_bad_shift_div
        $error("tt_dpll_scan_master: SHIFT_DIV must be >= 1");
    end

    scan_state_e          state_q, state_d;
    logic [CHAIN_LEN-1:0] sr_q, sr_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DW-1:0]        div_q, div_d;
    logic [CHAIN_LEN-1:0] rdata_d;
    logic                 busy_d, done_d, scan_en_d;

    // The registered scan-enable doubles as the divider tick, so the shift of
    // sr always lands on the same edge the chain shifts.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bit_d   = bit_q;
        div_d   = div_q;
        rdata_d = o_rdata;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    sr_d    = i_wdata;
                    bit_d   = '0;
                    div_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (o_scan_en) begin
                    sr_d  = {sr_q[CHAIN_LEN-2:0], i_scan_in};
                    bit_d = bit_q + BW'(1);
                    div_d = '0;
                    if (bit_d == BIT_LAST) begin
                        state_d = DONE;
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Capture on entry to DONE so o_rdata is already valid alongside o_done.
        if (state_d == DONE) begin
            rdata_d = sr_d;
        end
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
        scan_en_d = (state_d == SHIFT) && (div_d == DIV_LAST);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            bit_q     <= '0;
            div_q     <= '0;
            o_rdata   <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_scan_en <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_q     <= bit_d;
            div_q     <= div_d;
            o_rdata   <= rdata_d;
            o_busy    <= busy_d;
            o_done    <= done_d;
            o_scan_en <= scan_en_d;
        end
    end

    assign o_scan_out = sr_q[CHAIN_LEN-1];

endmodule

// File: tb/tb_tt_dpll_scan_master.sv
// tb/tb_tt_dpll_scan_master.sv - directed bench for tt_dpll_scan_master with chain models
module tb_tt_dpll_scan_master;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] sel;
    logic [7:0] wdata;
    logic [2:0] pl_en;
    logic [7:0] pl_val;

    logic       start_a, busy_a, done_a, en_a, so_a;
    logic [7:0] rdata_a, chain_a;
    logic       start_b, busy_b, done_b, en_b, so_b;
    logic [7:0] rdata_b, chain_b;
    logic       start_c, busy_c, done_c, en_c, so_c;
    logic [1:0] rdata_c, chain_c;

    logic       mon_en, mon_busy, mon_done;
    logic [7:0] mon_rdata, mon_chain;

    int checks;
    int errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign start_a = start && (sel == 2'd0);
    assign start_b = start && (sel == 2'd1);
    assign start_c = start && (sel == 2'd2);

    tt_dpll_scan_master #(.CHAIN_LEN(8), .SHIFT_DIV(1)) u_a (
        .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_wdata(wdata),
        .o_busy(busy_a), .o_done(done_a), .o_rdata(rdata_a),
        .o_scan_en(en_a), .o_scan_out(so_a), .i_scan_in(chain_a[7])
    );

    tt_dpll_scan_master #(.CHAIN_LEN(8), .SHIFT_DIV(3)) u_b (
        .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_wdata(wdata),
        .o_busy(busy_b), .o_done(done_b), .o_rdata(rdata_b),
        .o_scan_en(en_b), .o_scan_out(so_b), .i_scan_in(chain_b[7])
    );

    tt_dpll_scan_master #(.CHAIN_LEN(2), .SHIFT_DIV(1)) u_c (
        .i_clk(clk), .i_rst(rst), .i_start(start_c), .i_wdata(wdata[1:0]),
        .o_busy(busy_c), .o_done(done_c), .o_rdata(rdata_c),
        .o_scan_en(en_c), .o_scan_out(so_c), .i_scan_in(chain_c[1])
    );

    // Chain models: plain shift registers that shift on the DUT's scan enable.
    always @(posedge clk) begin
        if (pl_en[0])  chain_a <= pl_val;
        else if (en_a) chain_a <= {chain_a[6:0], so_a};
        if (pl_en[1])  chain_b <= pl_val;
        else if (en_b) chain_b <= {chain_b[6:0], so_b};
        if (pl_en[2])  chain_c <= pl_val[1:0];
        else if (en_c) chain_c <= {chain_c[0], so_c};
    end

    always_comb begin
        mon_en    = en_a;
        mon_busy  = busy_a;
        mon_done  = done_a;
        mon_rdata = rdata_a;
        mon_chain = chain_a;
        case (sel)
            2'd1: begin
                mon_en = en_b; mon_busy = busy_b; mon_done = done_b;
                mon_rdata = rdata_b; mon_chain = chain_b;
            end
            2'd2: begin
                mon_en = en_c; mon_busy = busy_c; mon_done = done_c;
                mon_rdata = {6'b0, rdata_c}; mon_chain = {6'b0, chain_c};
            end
            default: ;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [1:0] s, input logic [7:0] v);
        @(negedge clk);
        pl_val = v;
        pl_en  = 3'b001 << s;
        @(negedge clk);
        pl_en  = 3'b000;
    endtask

    // One full transfer; every cycle after the accepting edge is compared
    // against the expected busy / scan-enable profile.
    task automatic run_xfer(input logic [1:0] s, input int n, input int d,
                            input logic [7:0] wd, input logic [7:0] exp_rd,
                            input logic [7:0] exp_ch, input string name);
        int bad = 0;
        int pulses = 0;
        int done_cyc = -1;
        logic [7:0] rd_at_done = 8'hxx;
        logic exp_en, exp_busy;
        @(negedge clk);
        sel   = s;
        wdata = wd;
        start = 1'b1;
        for (int c = 1; c <= n * d + 3; c++) begin
            @(negedge clk);
            start    = 1'b0;
            exp_en   = (c <= n * d) && (c % d == 0);
            exp_busy = (c <= n * d + 1);
            if (mon_en !== exp_en || mon_busy !== exp_busy) bad++;
            if (mon_en === 1'b1) pulses++;
            if (mon_done === 1'b1) begin
                if (done_cyc < 0) done_cyc = c;
                rd_at_done = mon_rdata;
            end
        end
        check({name, " profile"}, bad, 0);
        check({name, " pulses"}, pulses, n);
        check({name, " done_cycle"}, done_cyc, n * d + 1);
        check({name, " rdata"}, rd_at_done, exp_rd);
        check({name, " chain"}, mon_chain, exp_ch);
    endtask

    typedef struct {
        logic [7:0] preload;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        logic [7:0] exp_chain;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int bad;
        logic exp_en, exp_busy, exp_done;
        logic [7:0] rd1, rd2;

        vecs[0] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vecs[1] = '{8'h5A, 8'hC3, 8'h5A, 8'hC3};
        vecs[2] = '{8'h01, 8'h80, 8'h01, 8'h80};
        vecs[3] = '{8'hFF, 8'h00, 8'hFF, 8'h00};

        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start  = 1'b0;
        sel    = 2'd0;
        wdata  = 8'h00;
        pl_en  = 3'b000;
        pl_val = 8'h00;

        repeat (2) @(negedge clk);
        check("reset busy", busy_a, 0);
        check("reset done", done_a, 0);
        check("reset scan_en", en_a, 0);
        check("reset rdata", rdata_a, 0);
        check("reset scan_out", so_a, 0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            preload(2'd0, vecs[i].preload);
            run_xfer(2'd0, 8, 1, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_chain,
                     $sformatf("vec%0d", i));
        end

        preload(2'd1, 8'h0F);
        run_xfer(2'd1, 8, 3, 8'hF0, 8'h0F, 8'hF0, "div3");

        preload(2'd2, 8'h01);
        run_xfer(2'd2, 2, 1, 8'h02, 8'h01, 8'h02, "len2");

        // Read-modify: chain holds 0x00 from the last table vector.
        run_xfer(2'd0, 8, 1, 8'hFF, 8'h00, 8'hFF, "rmw_ff");
        run_xfer(2'd0, 8, 1, 8'h00, 8'hFF, 8'h00, "rmw_00");

        // start held high with wdata changing mid-transfer; re-accept at E10.
        preload(2'd0, 8'h11);
        @(negedge clk);
        sel   = 2'd0;
        wdata = 8'hC3;
        start = 1'b1;
        bad   = 0;
        rd1   = 8'hxx;
        rd2   = 8'hxx;
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            if (c == 3)  wdata = 8'h99;
            if (c == 19) start = 1'b0;
            exp_busy = (c <= 9) || (c >= 11 && c <= 19);
            exp_en   = (c <= 8) || (c >= 11 && c <= 18);
            exp_done = (c == 9) || (c == 19);
            if (busy_a !== exp_busy || en_a !== exp_en || done_a !== exp_done) bad++;
            if (c == 9)  rd1 = rdata_a;
            if (c == 19) rd2 = rdata_a;
        end
        check("held_start profile", bad, 0);
        check("held_start rdata1", rd1, 8'h11);
        check("held_start rdata2", rd2, 8'hC3);
        check("held_start chain", chain_a, 8'h99);

        // Reset after four shifts, between clock edges.
        preload(2'd0, 8'hA5);
        @(negedge clk);
        sel   = 2'd0;
        wdata = 8'h3C;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst busy", busy_a, 1);
        rst = 1'b1;
        #1;
        check("mid_rst busy", busy_a, 0);
        check("mid_rst scan_en", en_a, 0);
        check("mid_rst done", done_a, 0);
        check("mid_rst rdata", rdata_a, 0);
        check("mid_rst chain", chain_a, 8'h53);
        @(negedge clk);
        rst = 1'b0;
        run_xfer(2'd0, 8, 1, 8'h55, 8'h53, 8'h55, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
